// File: rtl/multicycle_controller_if.sv
// Control interface between the multicycle controller and its datapath.
// master : controller side (reads instruction fields/ZeroFlag, drives controls)
// slave  : datapath side  (drives instruction fields/ZeroFlag, reads controls)
//   op[6:0], func3[2:0], func7b5, ZeroFlag          datapath -> controller
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,    controller -> datapath
//   ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0],
//   ImmSrc[2:0], AluOpcode[2:0], Illegal
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] func3;
  logic       func7b5;
  logic       ZeroFlag;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [2:0] AluOpcode;
  logic       Illegal;

  modport master (
    input  op, func3, func7b5, ZeroFlag,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, AluOpcode, Illegal
  );

  modport slave (
    output op, func3, func7b5, ZeroFlag,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, AluOpcode, Illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   ctrl_if  master modport: instruction fields + ZeroFlag in, datapath
//            controls (enables, mux selects, ImmSrc, AluOpcode, Illegal) out
// Controls are registered alongside the state (loaded from the next state),
// so each state's controls are valid for the whole cycle it is resident.
// Three outputs cannot be fully registered: DECODE sees the new opcode only
// in its own cycle (ImmSrc, Illegal), and branch PCWrite follows ZeroFlag.
module multicycle_controller (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_controller_if.master  ctrl_if
);

  localparam int unsigned OP_W  = 7;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned IMM_W = 3;
  localparam int unsigned ALU_W = 3;

  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

  localparam logic [ALU_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND  = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR   = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SLTU = 3'b100;
  localparam logic [ALU_W-1:0] ALU_SLT  = 3'b101;
  localparam logic [ALU_W-1:0] ALU_XOR  = 3'b110;

  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_MDR    = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;
  localparam logic [SEL_W-1:0] RES_IMM    = 2'b11;

  localparam logic [SEL_W-1:0] A_PC    = 2'b00;
  localparam logic [SEL_W-1:0] A_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] A_REG   = 2'b10;

  localparam logic [SEL_W-1:0] B_REG  = 2'b00;
  localparam logic [SEL_W-1:0] B_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] B_FOUR = 2'b10;

  localparam logic [IMM_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_W-1:0] IMM_J = 3'b011;
  localparam logic [IMM_W-1:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADR, S_MEM_READ, S_MEM_WB,
    S_MEM_WRITE, S_ALU_WB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI
  } state_t;

  state_t             state_q, state_d, dec_state_c;
  logic               illegal_c;

  logic               pc_write_q;
  logic               adr_src_q;
  logic               mem_write_q;
  logic               ir_write_q;
  logic               reg_write_q;
  logic [SEL_W-1:0]   result_src_q;
  logic [SEL_W-1:0]   alu_src_a_q;
  logic [SEL_W-1:0]   alu_src_b_q;
  logic [IMM_W-1:0]   imm_src_q;
  logic [ALU_W-1:0]   alu_op_q;
  logic               br_en_q;
  logic               br_inv_q;

  // func3 -> ALU op for R/I types; sub_en selects SUB on func3 000
  function automatic logic [ALU_W-1:0] alu_sel(input logic [F3_W-1:0] f3,
                                               input logic sub_en);
    case (f3)
      3'b000:  alu_sel = sub_en ? ALU_SUB : ALU_ADD;
      3'b111:  alu_sel = ALU_AND;
      3'b110:  alu_sel = ALU_OR;
      3'b100:  alu_sel = ALU_XOR;
      3'b010:  alu_sel = ALU_SLT;
      3'b011:  alu_sel = ALU_SLTU;
      default: alu_sel = ALU_ADD;
    endcase
  endfunction

  // Branch compare op; the taken test reads ZeroFlag of SUB/SLT/SLTU
  function automatic logic [ALU_W-1:0] br_alu_sel(input logic [F3_W-1:0] f3);
    case (f3)
      3'b000, 3'b001: br_alu_sel = ALU_SUB;
      3'b100, 3'b101: br_alu_sel = ALU_SLT;
      3'b110, 3'b111: br_alu_sel = ALU_SLTU;
      default:        br_alu_sel = ALU_ADD;
    endcase
  endfunction

  // bne/blt/bltu are taken when the ALU result is non-zero
  function automatic logic br_inv_sel(input logic [F3_W-1:0] f3);
    br_inv_sel = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
  endfunction

  // Opcode dispatch and legality check for the DECODE state
  always_comb begin
    illegal_c   = 1'b0;
    dec_state_c = S_FETCH;
    case (ctrl_if.op)
      OP_R: begin
        dec_state_c = S_EXEC_R;
        illegal_c   = (ctrl_if.func3 == 3'b001) || (ctrl_if.func3 == 3'b101);
      end
      OP_I: begin
        dec_state_c = S_EXEC_I;
        illegal_c   = (ctrl_if.func3 == 3'b001) || (ctrl_if.func3 == 3'b101);
      end
      OP_LOAD, OP_STORE: dec_state_c = S_MEM_ADR;
      OP_BRANCH: begin
        dec_state_c = S_BRANCH;
        illegal_c   = (ctrl_if.func3 == 3'b010) || (ctrl_if.func3 == 3'b011);
      end
      OP_JAL:  dec_state_c = S_JAL;
      OP_JALR: dec_state_c = S_JALR1;
      OP_LUI:  dec_state_c = S_LUI;
      default: illegal_c   = 1'b1;
    endcase
    if (illegal_c) begin
      dec_state_c = S_FETCH;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:                    state_d = S_DECODE;
      S_DECODE:                   state_d = dec_state_c;
      S_EXEC_R, S_EXEC_I, S_JAL:  state_d = S_ALU_WB;
      S_MEM_ADR:                  state_d = (ctrl_if.op == OP_STORE) ? S_MEM_WRITE
                                                                     : S_MEM_READ;
      S_MEM_READ:                 state_d = S_MEM_WB;
      S_JALR1:                    state_d = S_JALR2;
      default:                    state_d = S_FETCH;
    endcase
  end

  // State register plus controls for the state being entered. Reset parks
  // the controls at FETCH values so the first edge after release performs
  // the fetch; the write enables are masked by rst at the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_write_q   <= 1'b1;
      adr_src_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      ir_write_q   <= 1'b1;
      reg_write_q  <= 1'b0;
      result_src_q <= RES_ALU;
      alu_src_a_q  <= A_PC;
      alu_src_b_q  <= B_FOUR;
      imm_src_q    <= IMM_I;
      alu_op_q     <= ALU_ADD;
      br_en_q      <= 1'b0;
      br_inv_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_write_q   <= 1'b0;
      adr_src_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      ir_write_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= RES_ALUOUT;
      alu_src_a_q  <= A_PC;
      alu_src_b_q  <= B_REG;
      imm_src_q    <= IMM_I;
      alu_op_q     <= ALU_ADD;
      br_en_q      <= 1'b0;
      br_inv_q     <= 1'b0;
      case (state_d)
        S_FETCH: begin
          ir_write_q   <= 1'b1;
          pc_write_q   <= 1'b1;
          alu_src_b_q  <= B_FOUR;
          result_src_q <= RES_ALU;
        end
        S_DECODE: begin
          alu_src_a_q <= A_OLDPC;
          alu_src_b_q <= B_IMM;
        end
        S_EXEC_R: begin
          alu_src_a_q <= A_REG;
          alu_src_b_q <= B_REG;
          alu_op_q    <= alu_sel(ctrl_if.func3, ctrl_if.func7b5);
        end
        S_EXEC_I: begin
          alu_src_a_q <= A_REG;
          alu_src_b_q <= B_IMM;
          imm_src_q   <= IMM_I;
          alu_op_q    <= alu_sel(ctrl_if.func3, 1'b0);
        end
        S_ALU_WB: begin
          result_src_q <= RES_ALUOUT;
          reg_write_q  <= 1'b1;
        end
        S_MEM_ADR: begin
          alu_src_a_q <= A_REG;
          alu_src_b_q <= B_IMM;
          imm_src_q   <= (ctrl_if.op == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEM_READ: begin
          adr_src_q <= 1'b1;
        end
        S_MEM_WB: begin
          result_src_q <= RES_MDR;
          reg_write_q  <= 1'b1;
        end
        S_MEM_WRITE: begin
          adr_src_q   <= 1'b1;
          mem_write_q <= 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_q <= A_REG;
          alu_src_b_q <= B_REG;
          alu_op_q    <= br_alu_sel(ctrl_if.func3);
          br_en_q     <= 1'b1;
          br_inv_q    <= br_inv_sel(ctrl_if.func3);
        end
        S_JAL: begin
          alu_src_a_q <= A_OLDPC;
          alu_src_b_q <= B_FOUR;
          pc_write_q  <= 1'b1;
        end
        S_JALR1: begin
          alu_src_a_q  <= A_OLDPC;
          alu_src_b_q  <= B_FOUR;
          result_src_q <= RES_ALU;
          reg_write_q  <= 1'b1;
        end
        S_JALR2: begin
          alu_src_a_q  <= A_REG;
          alu_src_b_q  <= B_IMM;
          imm_src_q    <= IMM_I;
          result_src_q <= RES_ALU;
          pc_write_q   <= 1'b1;
        end
        S_LUI: begin
          imm_src_q    <= IMM_U;
          result_src_q <= RES_IMM;
          reg_write_q  <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Write enables are masked while rst is high so reset aborts immediately
  assign ctrl_if.PCWrite   = !rst && (pc_write_q ||
                                      (br_en_q && (ctrl_if.ZeroFlag ^ br_inv_q)));
  assign ctrl_if.IRWrite   = !rst && ir_write_q;
  assign ctrl_if.RegWrite  = !rst && reg_write_q;
  assign ctrl_if.MemWrite  = !rst && mem_write_q;
  assign ctrl_if.Illegal   = !rst && (state_q == S_DECODE) && illegal_c;

  assign ctrl_if.AdrSrc    = adr_src_q;
  assign ctrl_if.ResultSrc = result_src_q;
  assign ctrl_if.ALUSrcA   = alu_src_a_q;
  assign ctrl_if.ALUSrcB   = alu_src_b_q;
  assign ctrl_if.AluOpcode = alu_op_q;
  // DECODE picks the immediate format from the freshly loaded opcode
  assign ctrl_if.ImmSrc    = (state_q == S_DECODE)
                             ? ((ctrl_if.op == OP_JAL) ? IMM_J : IMM_B)
                             : imm_src_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected control
// vectors are queued when an instruction is driven and compared mid-cycle.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] res;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] imm;
    logic [2:0] alu;
    logic       ill;
  } ctl_t;

  typedef struct {
    string tag;
    ctl_t  c;
  } exp_t;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] LD_OP  = 7'b0000011;
  localparam logic [6:0] ST_OP  = 7'b0100011;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] JAL_OP = 7'b1101111;
  localparam logic [6:0] JR_OP  = 7'b1100111;
  localparam logic [6:0] LUI_OP = 7'b0110111;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  bit   fresh;
  exp_t sb[$];

  multicycle_controller_if ifc();

  multicycle_controller dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t obs();
    ctl_t c;
    c.pcw = ifc.PCWrite;   c.adr = ifc.AdrSrc;    c.mw  = ifc.MemWrite;
    c.irw = ifc.IRWrite;   c.rw  = ifc.RegWrite;  c.res = ifc.ResultSrc;
    c.a   = ifc.ALUSrcA;   c.b   = ifc.ALUSrcB;   c.imm = ifc.ImmSrc;
    c.alu = ifc.AluOpcode; c.ill = ifc.Illegal;
    return c;
  endfunction

  function automatic void push(input string tag, input ctl_t c);
    exp_t e;
    e.tag = tag;
    e.c   = c;
    sb.push_back(e);
  endfunction

  // Reference sequence of per-cycle controls for one instruction
  function automatic void model_instr(input logic [6:0] op, input logic [2:0] f3,
                                      input logic f7, input logic z);
    ctl_t       c;
    logic       ill;
    logic [2:0] aluv;
    c = '0; c.pcw = 1; c.irw = 1; c.res = 2'b10; c.b = 2'b10;
    push("fetch", c);
    case (op)
      R_OP, I_OP:                          ill = (f3 == 3'b001) || (f3 == 3'b101);
      LD_OP, ST_OP, JAL_OP, JR_OP, LUI_OP: ill = 1'b0;
      BR_OP:                               ill = (f3 == 3'b010) || (f3 == 3'b011);
      default:                             ill = 1'b1;
    endcase
    c = '0; c.a = 2'b01; c.b = 2'b01; c.ill = ill;
    c.imm = (op == JAL_OP) ? 3'b011 : 3'b010;
    push("decode", c);
    if (ill) return;
    case (f3)
      3'b000:  aluv = (op == R_OP && f7) ? 3'b001 : 3'b000;
      3'b111:  aluv = 3'b010;
      3'b110:  aluv = 3'b011;
      3'b100:  aluv = 3'b110;
      3'b010:  aluv = 3'b101;
      3'b011:  aluv = 3'b100;
      default: aluv = 3'b000;
    endcase
    case (op)
      R_OP: begin
        c = '0; c.a = 2'b10; c.b = 2'b00; c.alu = aluv; push("exec_r", c);
        c = '0; c.rw = 1; push("alu_wb", c);
      end
      I_OP: begin
        c = '0; c.a = 2'b10; c.b = 2'b01; c.alu = aluv; push("exec_i", c);
        c = '0; c.rw = 1; push("alu_wb", c);
      end
      LD_OP: begin
        c = '0; c.a = 2'b10; c.b = 2'b01; push("mem_adr_ld", c);
        c = '0; c.adr = 1; push("mem_read", c);
        c = '0; c.res = 2'b01; c.rw = 1; push("mem_wb", c);
      end
      ST_OP: begin
        c = '0; c.a = 2'b10; c.b = 2'b01; c.imm = 3'b001; push("mem_adr_st", c);
        c = '0; c.adr = 1; c.mw = 1; push("mem_write", c);
      end
      BR_OP: begin
        c = '0; c.a = 2'b10; c.b = 2'b00;
        case (f3)
          3'b000:  begin c.alu = 3'b001; c.pcw = z;  end
          3'b001:  begin c.alu = 3'b001; c.pcw = !z; end
          3'b100:  begin c.alu = 3'b101; c.pcw = !z; end
          3'b101:  begin c.alu = 3'b101; c.pcw = z;  end
          3'b110:  begin c.alu = 3'b100; c.pcw = !z; end
          default: begin c.alu = 3'b100; c.pcw = z;  end
        endcase
        push("branch", c);
      end
      JAL_OP: begin
        c = '0; c.a = 2'b01; c.b = 2'b10; c.pcw = 1; push("jal", c);
        c = '0; c.rw = 1; push("alu_wb", c);
      end
      JR_OP: begin
        c = '0; c.a = 2'b01; c.b = 2'b10; c.res = 2'b10; c.rw = 1; push("jalr1", c);
        c = '0; c.a = 2'b10; c.b = 2'b01; c.res = 2'b10; c.pcw = 1; push("jalr2", c);
      end
      default: begin
        c = '0; c.imm = 3'b100; c.res = 2'b11; c.rw = 1; push("lui", c);
      end
    endcase
  endfunction

  // Align to the start of a FETCH cycle, drive the fields, queue expectations
  task automatic begin_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z);
    if (!fresh) begin
      @(posedge clk);
      #1;
    end
    fresh        = 1'b0;
    ifc.op       = op;
    ifc.func3    = f3;
    ifc.func7b5  = f7;
    ifc.ZeroFlag = z;
    model_instr(op, f3, f7, z);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ifc.ZeroFlag = 1'b1;
    #1;
    checks++; if (ifc.PCWrite  !== 1'b0) begin failures++; $display("FAIL reset_pcwrite got %b want 0", ifc.PCWrite); end
    checks++; if (ifc.IRWrite  !== 1'b0) begin failures++; $display("FAIL reset_irwrite got %b want 0", ifc.IRWrite); end
    checks++; if (ifc.RegWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got %b want 0", ifc.RegWrite); end
    checks++; if (ifc.MemWrite !== 1'b0) begin failures++; $display("FAIL reset_memwrite got %b want 0", ifc.MemWrite); end
    checks++; if (ifc.Illegal  !== 1'b0) begin failures++; $display("FAIL reset_illegal got %b want 0", ifc.Illegal); end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    fresh = 1'b1;
  endtask

  task automatic test_rtype();
    logic [3:0] tbl [0:6] = '{4'b1000, 4'b0000, 4'b0111, 4'b0110, 4'b0100, 4'b0010, 4'b0011};
    exp_t e;
    ctl_t got;
    for (int i = 0; i < 7; i++) begin
      begin_instr(R_OP, tbl[i][2:0], tbl[i][3], 1'b0);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== e.c) begin
          failures++;
          $display("FAIL rtype_%s f3=%b f7=%b: got %h want %h", e.tag, tbl[i][2:0], tbl[i][3], got, e.c);
        end
      end
    end
  endtask

  task automatic test_itype();
    logic [3:0] tbl [0:5] = '{4'b1000, 4'b0111, 4'b0110, 4'b0100, 4'b0010, 4'b0011};
    exp_t e;
    ctl_t got;
    for (int i = 0; i < 6; i++) begin
      begin_instr(I_OP, tbl[i][2:0], tbl[i][3], 1'b1);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== e.c) begin
          failures++;
          $display("FAIL itype_%s f3=%b: got %h want %h", e.tag, tbl[i][2:0], got, e.c);
        end
      end
    end
  endtask

  task automatic test_mem();
    logic [6:0] ops [0:1] = '{LD_OP, ST_OP};
    exp_t e;
    ctl_t got;
    for (int i = 0; i < 2; i++) begin
      begin_instr(ops[i], 3'b010, 1'b0, 1'b1);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== e.c) begin
          failures++;
          $display("FAIL mem_%s op=%b: got %h want %h", e.tag, ops[i], got, e.c);
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [0:5] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    exp_t e;
    ctl_t got;
    for (int i = 0; i < 6; i++) begin
      for (int z = 0; z < 2; z++) begin
        begin_instr(BR_OP, f3s[i], 1'b0, z[0]);
        while (sb.size() != 0) begin
          e = sb.pop_front();
          @(negedge clk);
          got = obs();
          checks++;
          if (got !== e.c) begin
            failures++;
            $display("FAIL branch_%s f3=%b z=%0d: got %h want %h", e.tag, f3s[i], z, got, e.c);
          end
        end
      end
    end
  endtask

  task automatic test_jumps();
    logic [6:0] ops [0:2] = '{JAL_OP, JR_OP, LUI_OP};
    exp_t e;
    ctl_t got;
    for (int i = 0; i < 3; i++) begin
      begin_instr(ops[i], 3'b000, 1'b0, 1'b0);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== e.c) begin
          failures++;
          $display("FAIL jump_%s op=%b: got %h want %h", e.tag, ops[i], got, e.c);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [9:0] tbl [0:5] = '{{7'b1111111, 3'b000}, {R_OP, 3'b001}, {I_OP, 3'b101},
                              {BR_OP, 3'b010}, {BR_OP, 3'b011}, {7'b0000000, 3'b000}};
    exp_t e;
    ctl_t got;
    for (int i = 0; i < 6; i++) begin
      begin_instr(tbl[i][9:3], tbl[i][2:0], 1'b0, 1'b1);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== e.c) begin
          failures++;
          $display("FAIL illegal_%s op=%b f3=%b: got %h want %h", e.tag, tbl[i][9:3], tbl[i][2:0], got, e.c);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [0:9] = '{R_OP, I_OP, LD_OP, ST_OP, BR_OP, JAL_OP, JR_OP, LUI_OP,
                              7'b1111111, 7'b0001111};
    logic [6:0] op;
    logic [2:0] f3;
    exp_t e;
    ctl_t got;
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 9)];
      f3 = 3'($urandom_range(0, 7));
      begin_instr(op, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      while (sb.size() != 0) begin
        e = sb.pop_front();
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== e.c) begin
          failures++;
          $display("FAIL b2b_%s n=%0d op=%b f3=%b: got %h want %h", e.tag, n, op, f3, got, e.c);
        end
      end
    end
  endtask

  // Reset pulsed mid-store must kill MemWrite at once and restart at FETCH
  task automatic test_reset_midflight();
    exp_t e;
    ctl_t got;
    begin_instr(ST_OP, 3'b010, 1'b0, 1'b0);
    repeat (4) begin
      e = sb.pop_front();
      @(negedge clk);
      got = obs();
      checks++;
      if (got !== e.c) begin
        failures++;
        $display("FAIL midrst_%s: got %h want %h", e.tag, got, e.c);
      end
    end
    sb.delete();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (ifc.MemWrite !== 1'b0) begin failures++; $display("FAIL midrst_memwrite got %b want 0", ifc.MemWrite); end
    checks++; if (ifc.PCWrite  !== 1'b0) begin failures++; $display("FAIL midrst_pcwrite got %b want 0", ifc.PCWrite); end
    checks++; if (ifc.RegWrite !== 1'b0) begin failures++; $display("FAIL midrst_regwrite got %b want 0", ifc.RegWrite); end
    @(posedge clk);
    #1;
    checks++; if (ifc.IRWrite  !== 1'b0) begin failures++; $display("FAIL midrst_irwrite got %b want 0", ifc.IRWrite); end
    rst   = 1'b0;
    fresh = 1'b1;
  endtask

  initial begin
    rst          = 1'b1;
    fresh        = 1'b1;
    checks       = 0;
    failures     = 0;
    ifc.op       = 7'b0;
    ifc.func3    = 3'b0;
    ifc.func7b5  = 1'b0;
    ifc.ZeroFlag = 1'b0;
    test_reset();
    test_rtype();
    test_itype();
    test_mem();
    test_branch();
    test_jumps();
    test_illegal();
    test_back_to_back();
    test_reset_midflight();
    test_mem();
    test_rtype();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 op  in  7  instruction opcode field (IR[6:0]).
REQ-005 func3  in  3  IR[14:12].
REQ-006 func7b5  in  1  IR[30].
REQ-007 ZeroFlag  in  1  ALU zero flag, combinational from the current ALU result.
REQ-008 PCWrite  out  1  PC register load enable.
REQ-009 AdrSrc  out  1  memory address select: 0 = PC, 1 = Result bus.
REQ-010 MemWrite  out  1  data memory write enable.
REQ-011 IRWrite  out  1  IR and OldPC load enable.
REQ-012 RegWrite  out  1  register file write enable.
REQ-013 ResultSrc  out  2  Result bus select: 00 = ALUOut, 01 = memory data register, 10 = ALU result, 11 = immediate.
REQ-014 ALUSrcA  out  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = register A.
REQ-015 ALUSrcB  out  2  ALU operand B select: 00 = register B, 01 = immediate, 10 = constant 4.
REQ-016 ImmSrc  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
REQ-017 AluOpcode  out  3  ALU operation code: ADD 000, SUB 001, AND 010, OR 011, SLTU 100, SLT 101, XOR 110.
REQ-018 Illegal  out  1  one-cycle pulse marking an unsupported instruction.

Function
REQ-019 The controller SHALL be a Moore FSM, except that PCWrite in BRANCH depends on ZeroFlag. States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, ALU_WB, BRANCH, JAL, JALR1, JALR2, LUI.
REQ-020 Every output not listed for a state SHALL be 0 in that state (AluOpcode = ADD).
REQ-021 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Next state: DECODE.
REQ-022 DECODE: ALUSrcA=01, ALUSrcB=01, ADD; ImmSrc=011 if op=1101111, otherwise 010. Next state is selected by op:
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 0000011 or 0100011 -> MEM_ADR
- 1100011 -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR1
- 0110111 -> LUI
REQ-023 Illegal decode: an unknown op, an unsupported func3, or an unsupported branch func3 SHALL make DECODE go to FETCH with Illegal=1 for that DECODE cycle and no write enables asserted.
REQ-024 EXEC_R: ALUSrcA=10, ALUSrcB=00. func3/func7b5 map: 000/0 ADD, 000/1 SUB, 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU. Next state: ALU_WB. All other func3 values are illegal.
REQ-025 EXEC_I: ALUSrcA=10, ALUSrcB=01, ImmSrc=000. Same func3 map as EXEC_R, except func3 000 always gives ADD. Next state: ALU_WB.
REQ-026 ALU_WB: ResultSrc=00, RegWrite=1. Next state: FETCH.
REQ-027 MEM_ADR: ALUSrcA=10, ALUSrcB=01, ADD; ImmSrc=000 for loads, 001 for stores. Next state: MEM_READ for loads, MEM_WRITE for stores.
REQ-028 MEM_READ: AdrSrc=1, ResultSrc=00. Next state: MEM_WB.
REQ-029 MEM_WB: ResultSrc=01, RegWrite=1. Next state: FETCH.
REQ-030 MEM_WRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Next state: FETCH.
REQ-031 BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00. Next state: FETCH. Opcode and PCWrite by func3:
- 000 (beq): SUB, PCWrite=ZeroFlag
- 001 (bne): SUB, PCWrite=!ZeroFlag
- 100 (blt): SLT, PCWrite=!ZeroFlag
- 101 (bge): SLT, PCWrite=ZeroFlag
- 110 (bltu): SLTU, PCWrite=!ZeroFlag
- 111 (bgeu): SLTU, PCWrite=ZeroFlag
REQ-032 JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1. Next state: ALU_WB (writes OldPC+4 to rd).
REQ-033 JALR1: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10, RegWrite=1. Next state: JALR2.
REQ-034 JALR2: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ADD, ResultSrc=10, PCWrite=1. Next state: FETCH. Correct when rd==rs1 because register A was latched earlier.
REQ-035 LUI: ImmSrc=100, ResultSrc=11, RegWrite=1. Next state: FETCH.
REQ-036 Instruction latency in cycles: R, I, lui, branch = 3 or 4 as listed by state path; lw = 5; sw = 4; jal = 4; jalr = 4.

Reset
REQ-037 While rst=1, state SHALL be FETCH and PCWrite, IRWrite, RegWrite, MemWrite and Illegal SHALL be forced to 0.
REQ-038 The first FETCH SHALL be the first rising edge after rst deasserts.
REQ-039 Reset asserted in any state SHALL abort the instruction immediately with no further write enable.

Verification
REQ-040 After reset, op=0110011, func3=000, func7b5=1 -> FETCH, DECODE, EXEC_R (AluOpcode=001), ALU_WB (RegWrite=1), then FETCH.
REQ-041 op=0000011 -> five-cycle path; MEM_READ AdrSrc=1; MEM_WB ResultSrc=01, RegWrite=1; MemWrite=0 throughout.
REQ-042 beq with ZeroFlag=1 -> PCWrite=1 in BRANCH; bge with ZeroFlag=0 -> PCWrite=0, AluOpcode=101.
REQ-043 op=1100111 -> JALR1 RegWrite=1, JALR2 PCWrite=1 with ImmSrc=000.
REQ-044 op=1111111 -> Illegal=1 in DECODE only, next state FETCH, no RegWrite or MemWrite.
REQ-045 rst pulsed during MEM_WRITE -> MemWrite drops asynchronously, and the FETCH sequence restarts after release.
